// File: rtl/lcd_stream_writer.sv
// Replays picture-ROM {byte, rs} entries as 8080-style writes on the LCD bus.
// Every output is a register, loaded from the next-state decode so it lines up with the state.
`timescale 1ns/1ps
module lcd_stream_writer #(
    parameter int SETUP_CYC  = 1,
    parameter int WR_LOW_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [8:0] rom_d_i,
    input  logic [9:0] rom_length_i,
    output logic       rom_sync_o,
    output logic       rom_en_n_o,
    output logic       lcd_cs_n_o,
    output logic       lcd_rs_o,
    output logic       lcd_wr_n_o,
    output logic [7:0] lcd_d_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {IDLE, SYNC, LOAD, SETUP, WR_LO, WR_HI, ADV, DONE} state_t;

    state_t     state, state_n;
    logic [3:0] cnt;
    logic [9:0] idx;
    logic [9:0] len;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i && !abort_i) state_n = SYNC;
            SYNC:    state_n = LOAD;
            LOAD:    state_n = SETUP;
            SETUP:   if (cnt == '0) state_n = WR_LO;
            WR_LO:   if (cnt == '0) state_n = WR_HI;
            WR_HI:   if (cnt == '0) state_n = (idx == len) ? DONE : ADV;
            ADV:     state_n = LOAD;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort_i && state != IDLE) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            len        <= '0;
            rom_sync_o <= 1'b0;
            rom_en_n_o <= 1'b1;
            lcd_cs_n_o <= 1'b1;
            lcd_wr_n_o <= 1'b1;
            lcd_rs_o   <= 1'b0;
            lcd_d_o    <= 8'h00;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state <= state_n;

            // Phase counter reloads on every phase entry and counts down to zero.
            if (state_n != state) begin
                case (state_n)
                    SETUP:   cnt <= 4'(SETUP_CYC - 1);
                    WR_LO:   cnt <= 4'(WR_LOW_CYC - 1);
                    WR_HI:   cnt <= 4'(HOLD_CYC - 1);
                    default: cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 4'd1;
            end

            if (state == SYNC) idx <= '0;
            else if (state == ADV) idx <= idx + 10'd1;

            // ROM output is valid during LOAD; D/RS never move anywhere else.
            if (state == LOAD) begin
                lcd_d_o  <= rom_d_i[8:1];
                lcd_rs_o <= rom_d_i[0];
                if (idx == '0) len <= rom_length_i;
            end

            if (state_n == IDLE) lcd_cs_n_o <= 1'b1;
            else if (state == LOAD) lcd_cs_n_o <= 1'b0;

            rom_sync_o <= (state_n == SYNC);
            rom_en_n_o <= (state_n != ADV);
            lcd_wr_n_o <= (state_n != WR_LO);
            busy_o     <= (state_n != IDLE);
            done_o     <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_lcd_stream_writer.sv
// Bench for lcd_stream_writer: a ROM model feeds the DUT, a bus monitor records writes,
// and each transfer is compared against the ROM contents and the counts implied by its length.
`timescale 1ns/1ps
module tb_lcd_stream_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, abort_i;
    logic [8:0] rom_d_i;
    logic [9:0] rom_length_i;
    logic       rom_sync_o, rom_en_n_o, lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, busy_o, done_o;
    logic [7:0] lcd_d_o;

    always #5 clk = ~clk;

    lcd_stream_writer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .rom_d_i(rom_d_i), .rom_length_i(rom_length_i),
        .rom_sync_o(rom_sync_o), .rom_en_n_o(rom_en_n_o), .lcd_cs_n_o(lcd_cs_n_o),
        .lcd_rs_o(lcd_rs_o), .lcd_wr_n_o(lcd_wr_n_o), .lcd_d_o(lcd_d_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // Picture ROM: address restarts on sync, advances on en_n low.
    logic [8:0] mem [0:1023];
    logic [9:0] addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr <= '0;
        else if (rom_sync_o) addr <= '0;
        else if (!rom_en_n_o) addr <= addr + 10'd1;
    end
    assign rom_d_i = mem[addr];

    // Bus monitor, sampled on the falling edge.
    int wr_pulses = 0, wr_low = 0, en_pulses = 0, sync_pulses = 0, done_pulses = 0;
    int viol_d = 0, viol_en = 0, viol_sync = 0, cap_n = 0;
    logic [8:0] cap [0:1023];
    logic       prev_wr = 1'b1, prev_en = 1'b1, prev_sync = 1'b0, prev_done = 1'b0;
    logic [8:0] prev_drs = '0;

    always @(negedge clk) begin
        if (!prev_wr && lcd_wr_n_o) begin
            cap[cap_n[9:0]] <= {lcd_d_o, lcd_rs_o};
            cap_n <= cap_n + 1;
        end
        if (prev_wr && !lcd_wr_n_o) wr_pulses <= wr_pulses + 1;
        if (!lcd_wr_n_o) wr_low <= wr_low + 1;
        if (prev_en && !rom_en_n_o) en_pulses <= en_pulses + 1;
        if (!prev_sync && rom_sync_o) sync_pulses <= sync_pulses + 1;
        if (!prev_done && done_o) done_pulses <= done_pulses + 1;
        if (!lcd_wr_n_o && !prev_wr && {lcd_d_o, lcd_rs_o} != prev_drs) viol_d <= viol_d + 1;
        if (!rom_en_n_o && !prev_en) viol_en <= viol_en + 1;
        if (rom_sync_o && prev_sync) viol_sync <= viol_sync + 1;
        prev_wr   <= lcd_wr_n_o;
        prev_en   <= rom_en_n_o;
        prev_sync <= rom_sync_o;
        prev_done <= done_o;
        prev_drs  <= {lcd_d_o, lcd_rs_o};
    end

    int checks = 0, errors = 0;
    int b_wr, b_low, b_en, b_sync, b_done, b_cap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_wr = wr_pulses; b_low = wr_low; b_en = en_pulses;
        b_sync = sync_pulses; b_done = done_pulses; b_cap = cap_n;
    endtask

    task automatic fill_rom(input int len);
        for (int i = 0; i <= len; i++) mem[i] = {8'($urandom), 1'($urandom)};
        if (len == 50) begin
            mem[0]  = {8'h3E, 1'b0};
            mem[1]  = {8'hBD, 1'b0};
            mem[2]  = {8'h6E, 1'b0};
            mem[3]  = {8'h03, 1'b1};
            mem[49] = {8'h80, 1'b1};
            mem[50] = {8'h3F, 1'b0};
        end
        rom_length_i = 10'(len);
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (done_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("done_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Expected behaviour of one complete transfer of entries 0..len.
    task automatic check_transfer(input int len);
        logic [9:0] ci;
        chk("wr_pulses",   32'(wr_pulses - b_wr),    32'(len + 1));
        chk("wr_low_cyc",  32'(wr_low - b_low),      32'((len + 1) * 2));
        chk("en_pulses",   32'(en_pulses - b_en),    32'(len));
        chk("sync_pulses", 32'(sync_pulses - b_sync), 32'd1);
        chk("done_pulses", 32'(done_pulses - b_done), 32'd1);
        chk("captures",    32'(cap_n - b_cap),        32'(len + 1));
        chk("busy_after",  32'(busy_o),  32'd0);
        chk("cs_after",    32'(lcd_cs_n_o), 32'd1);
        for (int k = 0; k <= len; k++) begin
            ci = 10'(b_cap + k);
            chk("scoreboard", 32'(cap[ci]), 32'(mem[k]));
        end
    endtask

    task automatic check_reset();
        chk("rst_sync", 32'(rom_sync_o), 32'd0);
        chk("rst_en_n", 32'(rom_en_n_o), 32'd1);
        chk("rst_cs_n", 32'(lcd_cs_n_o), 32'd1);
        chk("rst_wr_n", 32'(lcd_wr_n_o), 32'd1);
        chk("rst_rs",   32'(lcd_rs_o),   32'd0);
        chk("rst_d",    32'(lcd_d_o),    32'd0);
        chk("rst_busy", 32'(busy_o),     32'd0);
        chk("rst_done", 32'(done_o),     32'd0);
    endtask

    initial begin
        bit reached;
        int k, n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; rom_length_i = '0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // start together with abort in IDLE: abort wins
        fill_rom(50);
        snap();
        @(negedge clk); start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_abort_busy", 32'(busy_o), 32'd0);
        chk("start_abort_sync", 32'(sync_pulses - b_sync), 32'd0);

        // full 51-entry transfer with a stray start mid-transfer
        snap();
        pulse_start();
        chk("busy_after_start", 32'(busy_o), 32'd1);
        repeat (60) @(negedge clk);
        chk("busy_mid", 32'(busy_o), 32'd1);
        pulse_start();
        wait_done(1000);
        check_transfer(50);
        chk("protocol_d", 32'(viol_d), 32'd0);

        // length-0 ROM: one write, done 7 cycles after start
        fill_rom(0);
        snap();
        pulse_start();
        k = 1;
        while (!done_o && k < 50) begin @(negedge clk); k++; end
        chk("len0_latency", 32'(k), 32'd7);
        repeat (3) @(negedge clk);
        check_transfer(0);

        // abort while WR_n is low at a random write
        fill_rom(50);
        snap();
        pulse_start();
        n = $urandom_range(1, 40);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!lcd_wr_n_o && (wr_pulses - b_wr) >= n) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        chk("abort_reach", 32'(reached), 32'd1);
        abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
        chk("abort_wr_n", 32'(lcd_wr_n_o), 32'd1);
        chk("abort_cs_n", 32'(lcd_cs_n_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", 32'(done_pulses - b_done), 32'd0);
        snap();
        pulse_start();
        wait_done(1000);
        check_transfer(50);

        // async reset during SETUP of entry 10
        fill_rom(50);
        snap();
        pulse_start();
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ((en_pulses - b_en) == 10 && rom_en_n_o) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        chk("reset_reach", 32'(reached), 32'd1);
        @(negedge clk);
        chk("setup_entry10", 32'({lcd_d_o, lcd_rs_o}), 32'(mem[10]));
        chk("setup_wr_n", 32'(lcd_wr_n_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_no_done", 32'(done_pulses - b_done), 32'd0);
        snap();
        pulse_start();
        wait_done(1000);
        check_transfer(50);
        chk("restart_entry0", 32'(cap[10'(b_cap)]), 32'h07C);

        chk("protocol_d_final", 32'(viol_d), 32'd0);
        chk("protocol_en",      32'(viol_en), 32'd0);
        chk("protocol_sync",    32'(viol_sync), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
